// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, DIGITS
// common-anode digits, dead-time anti-ghosting, per-digit blink and blanking.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       1 = scanning, 0 = display dark
//   digits_in    packed BCD, nibble i drives digit i (digit 0 rightmost)
//   blink_mask   bit i = 1 blinks digit i
//   bcd          nibble to the shared decoder (registered)
//   digit_en_n   active-low digit select, one-hot-low or all-high (registered)
//   frame_start  one-cycle pulse on the first cycle of a digit-0 slot
module display_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD_CYC     = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [15:0]   DIV_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0]   DEAD_LAST = 16'(DEAD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [9:0]    BLK_LAST  = 10'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ON
    } state_t;

    state_t                state, nstate;
    logic [15:0]           cnt, ncnt;
    logic [IW-1:0]         idx, nidx;
    logic [9:0]            bcnt, nbcnt;
    logic                  phase, nphase;
    logic [4*DIGITS-1:0]   snap_d, nsnap_d;
    logic [DIGITS-1:0]     snap_m, nsnap_m;
    logic                  load;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     sel;
    logic                  lit;

    // Next-state view; outputs are registered from it so they stay
    // aligned with the state/index they describe.
    always_comb begin
        nstate  = state;
        ncnt    = cnt;
        nidx    = idx;
        nbcnt   = bcnt;
        nphase  = phase;
        load    = 1'b0;
        if (!enable) begin
            nstate = IDLE;
            ncnt   = '0;
            nidx   = '0;
            nbcnt  = '0;
            nphase = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    nstate = DEAD;
                    ncnt   = '0;
                    nidx   = '0;
                    nbcnt  = '0;
                    nphase = 1'b0;
                    load   = 1'b1;
                end
                DEAD: begin
                    ncnt = cnt + 16'd1;
                    if (cnt == DEAD_LAST) nstate = ON;
                end
                ON: begin
                    if (cnt == DIV_LAST) begin
                        nstate = DEAD;
                        ncnt   = '0;
                        if (idx == IDX_LAST) begin
                            nidx = '0;
                            load = 1'b1;
                            // Blink phase flips once per BLINK_FRAMES wraps.
                            if (bcnt == BLK_LAST) begin
                                nbcnt  = '0;
                                nphase = ~phase;
                            end else begin
                                nbcnt = bcnt + 10'd1;
                            end
                        end else begin
                            nidx = idx + 1'b1;
                        end
                    end else begin
                        ncnt = cnt + 16'd1;
                    end
                end
                default: nstate = IDLE;
            endcase
        end
        nsnap_d = load ? digits_in  : snap_d;
        nsnap_m = load ? blink_mask : snap_m;
        nib     = nsnap_d[{nidx, 2'b00} +: 4];
        sel     = '0;
        sel[nidx] = 1'b1;
        lit = (nstate == ON) && (nib <= 4'd9) &&
              !(nphase && nsnap_m[nidx]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            bcnt        <= '0;
            phase       <= 1'b0;
            snap_d      <= '0;
            snap_m      <= '0;
            bcd         <= 4'h0;
            digit_en_n  <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= nstate;
            cnt         <= ncnt;
            idx         <= nidx;
            bcnt        <= nbcnt;
            phase       <= nphase;
            snap_d      <= nsnap_d;
            snap_m      <= nsnap_m;
            bcd         <= nib;
            digit_en_n  <= lit ? ~sel : '1;
            frame_start <= (nstate == DEAD) && (ncnt == '0) &&
                           (nidx == '0);
        end
    end

endmodule
